// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter: per-requester FIFOs, round-robin grant, one write per cycle.
// An entry reaches DstReg/DstData the cycle after it is accepted; ready depends only on FIFO occupancy.
module rf_write_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [3:0]  a_reg,
  input  logic [15:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [3:0]  b_reg,
  input  logic [15:0] b_data,
  output logic        b_ready,
  output logic        WriteReg,
  output logic [3:0]  DstReg,
  output logic [15:0] DstData,
  output logic [15:0] busy_mask,
  output logic [15:0] conflict_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  // Index 0 is requester A (ALU), index 1 is requester B (memory).
  logic [3:0]       regMem   [2][DEPTH];
  logic [15:0]      dataMem  [2][DEPTH];
  logic [DEPTH-1:0] occupied [2];
  logic [PW-1:0]    wrPtr    [2];
  logic [PW-1:0]    rdPtr    [2];
  logic [CW-1:0]    count    [2];
  logic             lastGrant;
  logic [15:0]      conflictCnt;

  logic [1:0]  inValid;
  logic [1:0]  ready;
  logic [1:0]  push;
  logic [1:0]  pop;
  logic [1:0]  nonEmpty;
  logic [3:0]  inReg  [2];
  logic [15:0] inData [2];
  logic        grantB;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign inValid   = {b_valid, a_valid};
  assign inReg[0]  = a_reg;
  assign inReg[1]  = b_reg;
  assign inData[0] = a_data;
  assign inData[1] = b_data;

  assign a_ready      = ready[0];
  assign b_ready      = ready[1];
  assign conflict_cnt = conflictCnt;

  always_comb begin
    ready    = '0;
    nonEmpty = '0;
    push     = '0;
    for (int r = 0; r < 2; r++) begin
      ready[r]    = (count[r] < CW'(DEPTH));
      nonEmpty[r] = (count[r] != '0);
      push[r]     = inValid[r] && ready[r];
    end
  end

  // B wins only when A is empty or A took the previous grant.
  always_comb begin
    grantB   = nonEmpty[1] && (!nonEmpty[0] || lastGrant == GRANT_A);
    pop      = {grantB, nonEmpty[0] && !grantB};
    WriteReg = |nonEmpty;
    DstReg   = '0;
    DstData  = '0;
    if (grantB) begin
      DstReg  = regMem[1][rdPtr[1]];
      DstData = dataMem[1][rdPtr[1]];
    end else if (nonEmpty[0]) begin
      DstReg  = regMem[0][rdPtr[0]];
      DstData = dataMem[0][rdPtr[0]];
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (occupied[r][i]) busy_mask[regMem[r][i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 2; r++) begin
        wrPtr[r]    <= '0;
        rdPtr[r]    <= '0;
        count[r]    <= '0;
        occupied[r] <= '0;
      end
      lastGrant   <= GRANT_B;
      conflictCnt <= '0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (push[r]) wrPtr[r] <= nextPtr(wrPtr[r]);
        if (pop[r])  rdPtr[r] <= nextPtr(rdPtr[r]);
        count[r]    <= count[r] + CW'(push[r]) - CW'(pop[r]);
        occupied[r] <= (occupied[r] & ~(DEPTH'(pop[r]) << rdPtr[r]))
                     | (DEPTH'(push[r]) << wrPtr[r]);
      end
      if (|pop) lastGrant <= pop[1] ? GRANT_B : GRANT_A;
      if (&nonEmpty && conflictCnt != 16'hFFFF) conflictCnt <= conflictCnt + 16'd1;
    end
  end

  // Storage needs no reset: occupancy gates every use of it.
  always_ff @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (push[r]) begin
        regMem[r][wrPtr[r]]  <= inReg[r];
        dataMem[r][wrPtr[r]] <= inData[r];
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: queue-based reference model feeds an expected-write scoreboard;
// a negedge monitor pops it on every DUT write and also checks ready, busy mask and conflict count.
module tb_rf_write_arbiter;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [3:0]  a_reg, b_reg;
  logic [15:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic [15:0] busy_mask;
  logic [15:0] conflict_cnt;

  always #5 clk = ~clk;

  rf_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
    .busy_mask(busy_mask), .conflict_cnt(conflict_cnt)
  );

  typedef struct packed {
    logic [3:0]  r;
    logic [15:0] d;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  ent_t expQ[$];
  bit          lastWasA;
  int unsigned cntModel;
  bit          checkEn = 1'b0;
  bit          expWrite;
  logic        expAReady, expBReady;
  logic [15:0] expMask, expCnt;
  bit          lastAccA, lastAccB;
  int          pA, pB;
  int          tests = 0;
  int          fails = 0;

  function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit modelGrantA();
    return qa.size() > 0 && (qb.size() == 0 || !lastWasA);
  endfunction

  // Applies the edge that just happened, using the inputs that were held across it.
  task automatic modelEdge(output bit accA, output bit accB);
    accA = 1'b0;
    accB = 1'b0;
    if (rst) begin
      qa.delete();
      qb.delete();
      lastWasA = 1'b0;
      cntModel = 0;
      checkEn  = 1'b1;
      return;
    end
    accA = a_valid && (qa.size() < DEPTH);
    accB = b_valid && (qb.size() < DEPTH);
    if (qa.size() > 0 && qb.size() > 0 && cntModel < 65535) cntModel++;
    if (modelGrantA()) begin
      void'(qa.pop_front());
      lastWasA = 1'b1;
    end else if (qb.size() > 0) begin
      void'(qb.pop_front());
      lastWasA = 1'b0;
    end
    if (accA) qa.push_back('{r: a_reg, d: a_data});
    if (accB) qb.push_back('{r: b_reg, d: b_data});
  endtask

  task automatic setExpect();
    expAReady = (qa.size() < DEPTH);
    expBReady = (qb.size() < DEPTH);
    expCnt    = cntModel[15:0];
    expMask   = '0;
    foreach (qa[i]) expMask[qa[i].r] = 1'b1;
    foreach (qb[i]) expMask[qb[i].r] = 1'b1;
    expWrite = (qa.size() > 0) || (qb.size() > 0);
    if (modelGrantA()) expQ.push_back(qa[0]);
    else if (qb.size() > 0) expQ.push_back(qb[0]);
  endtask

  task automatic step();
    bit accA, accB;
    @(posedge clk);
    #1;
    modelEdge(accA, accB);
    lastAccA = accA;
    lastAccB = accB;
    setExpect();
  endtask

  // A requester keeps an unaccepted request unchanged until it is taken.
  task automatic driveRandom();
    if (!a_valid || lastAccA) begin
      a_valid = ($urandom_range(99) < pA);
      a_reg   = 4'($urandom);
      a_data  = 16'($urandom);
    end
    if (!b_valid || lastAccB) begin
      b_valid = ($urandom_range(99) < pB);
      b_reg   = 4'($urandom);
      b_data  = 16'($urandom);
    end
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (checkEn) begin
      chk("a_ready", {15'd0, a_ready}, {15'd0, expAReady});
      chk("b_ready", {15'd0, b_ready}, {15'd0, expBReady});
      chk("busy_mask", busy_mask, expMask);
      chk("conflict_cnt", conflict_cnt, expCnt);
      chk("WriteReg", {15'd0, WriteReg}, {15'd0, expWrite});
      if (WriteReg) begin
        if (expQ.size() == 0) begin
          chk("write_unexpected", 16'd1, 16'd0);
        end else begin
          e = expQ.pop_front();
          chk("DstReg", {12'd0, DstReg}, {12'd0, e.r});
          chk("DstData", DstData, e.d);
        end
      end else begin
        if (expWrite && expQ.size() > 0) void'(expQ.pop_front());
        chk("DstReg_idle", {12'd0, DstReg}, 16'd0);
        chk("DstData_idle", DstData, 16'd0);
      end
    end
  end

  initial begin
    int bSent;
    rst = 1'b1;
    a_valid = 1'b0; a_reg = '0; a_data = '0;
    b_valid = 1'b0; b_reg = '0; b_data = '0;
    pA = 0; pB = 0;
    step(); step();
    rst = 1'b0;
    step();

    // Single write from A.
    a_valid = 1'b1; a_reg = 4'd3; a_data = 16'h1234;
    step();
    a_valid = 1'b0;
    repeat (3) step();

    // Simultaneous first requests after reset: A must win.
    rst = 1'b1; step(); rst = 1'b0;
    a_valid = 1'b1; a_reg = 4'd1; a_data = 16'hAAAA;
    b_valid = 1'b1; b_reg = 4'd2; b_data = 16'hBBBB;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    @(negedge clk); #1;
    chk("conflict_after_reset", conflict_cnt, 16'd1);
    repeat (2) step();

    // A floods while B pushes three entries back to back.
    pA = 100; pB = 0; bSent = 0;
    driveRandom();
    repeat (14) begin
      if (!b_valid || lastAccB) begin
        if (bSent < 3) begin
          b_valid = 1'b1; b_reg = 4'(bSent + 5); b_data = 16'hB000 + 16'(bSent);
          bSent++;
        end else begin
          b_valid = 1'b0;
        end
      end
      step();
      driveRandom();
    end

    // Uncontested A stream, one write per cycle.
    pA = 0; pB = 0; driveRandom();
    repeat (3) step();
    pA = 100; driveRandom();
    repeat (12) begin step(); driveRandom(); end

    // Reset with both FIFOs full while requests keep arriving.
    pA = 100; pB = 100;
    repeat (8) begin step(); driveRandom(); end
    rst = 1'b1; step(); rst = 1'b0;
    repeat (8) begin step(); driveRandom(); end

    // Random traffic mixes with occasional resets, register 0 included.
    for (int blk = 0; blk < 20; blk++) begin
      pA = 25 * $urandom_range(4);
      pB = 25 * $urandom_range(4);
      repeat (100) begin
        rst = ($urandom_range(149) == 0);
        step();
        driveRandom();
      end
    end
    rst = 1'b0;

    // Saturation: continuous contention past 65535 conflict cycles.
    rst = 1'b1; step(); rst = 1'b0;
    pA = 100; pB = 100; driveRandom();
    repeat (65560) begin step(); driveRandom(); end
    @(negedge clk); #1;
    chk("conflict_saturated", conflict_cnt, 16'hFFFF);

    // Drain and confirm every predicted write appeared.
    pA = 0; pB = 0;
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (8) step();
    @(negedge clk); #1;
    chk("expq_drained", 16'(expQ.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
